// File: rtl/nes_mapper_pkg.sv
// Shared constants for the NES cartridge mapper: mapper modes,
// MMC1 mirroring encodings and MMC1 register indices.
package nes_mapper_pkg;

    localparam logic [1:0] MODE_NROM  = 2'd0;
    localparam logic [1:0] MODE_MMC1  = 2'd1;
    localparam logic [1:0] MODE_UXROM = 2'd2;
    localparam logic [1:0] MODE_CNROM = 2'd3;

    localparam logic [1:0] MIR_ONE_LO = 2'd0;
    localparam logic [1:0] MIR_ONE_HI = 2'd1;
    localparam logic [1:0] MIR_VERT   = 2'd2;
    localparam logic [1:0] MIR_HORZ   = 2'd3;

    localparam logic [1:0] REG_CTRL = 2'd0;
    localparam logic [1:0] REG_CHR0 = 2'd1;
    localparam logic [1:0] REG_CHR1 = 2'd2;
    localparam logic [1:0] REG_PRG  = 2'd3;

    localparam logic [4:0] CTRL_RESET = 5'h0C;

endpackage

// File: rtl/mmc1_loader.sv
// MMC1 serial port: 5-write LSB-first shift loader with reset writes
// and suppression of back-to-back (read-modify-write) writes.
module mmc1_loader
    import nes_mapper_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       ce_i,
    input  logic       wr_i,
    input  logic       en_i,
    input  logic       d7_i,
    input  logic       d0_i,
    input  logic [1:0] idx_i,
    output logic       ld_o,
    output logic       clr_o,
    output logic [1:0] idx_o,
    output logic [4:0] data_o
);

    logic [4:0] shift_q, shift_d;
    logic [2:0] count_q, count_d;
    logic       prev_q, prev_d;
    logic       take;
    logic       unused_ok;

    assign take      = en_i & wr_i & ~prev_q;
    assign idx_o     = idx_i;
    assign data_o    = {d0_i, shift_q[4:1]};
    assign unused_ok = shift_q[0];

    always_comb begin
        shift_d = shift_q;
        count_d = count_q;
        prev_d  = prev_q;
        ld_o    = 1'b0;
        clr_o   = 1'b0;
        // prev tracks only cycles the CPU actually executes
        if (ce_i) begin
            prev_d = wr_i;
        end
        if (take) begin
            if (d7_i) begin
                shift_d = '0;
                count_d = '0;
                clr_o   = 1'b1;
            end else if (count_q == 3'd4) begin
                shift_d = '0;
                count_d = '0;
                ld_o    = 1'b1;
            end else begin
                shift_d = {d0_i, shift_q[4:1]};
                count_d = count_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shift_q <= '0;
            count_q <= '0;
            prev_q  <= 1'b0;
        end else begin
            shift_q <= shift_d;
            count_q <= count_d;
            prev_q  <= prev_d;
        end
    end

endmodule

// File: rtl/nes_mapper.sv
// NES cartridge mapper covering NROM, MMC1, UxROM and CNROM boards;
// all bus outputs are combinational from the registers and inputs.
module nes_mapper
    import nes_mapper_pkg::*;
#(
    parameter int PRG_AW = 18,
    parameter int CHR_AW = 17
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ce,
    input  logic [1:0]        mode,
    input  logic              mirror_v,
    input  logic              chr_ram,
    input  logic [15:0]       cpu_a,
    input  logic [7:0]        cpu_d,
    input  logic              cpu_w,
    input  logic [13:0]       ppu_a,
    output logic [PRG_AW-1:0] prg_a,
    output logic [CHR_AW-1:0] chr_a,
    output logic              chr_we,
    output logic              nt_a10,
    output logic              prg_ram_en
);

    localparam int PB = PRG_AW - 14;
    localparam int CB = CHR_AW - 12;

    logic [4:0]    ctrl_q, chr0_q, chr1_q, prg_q;
    logic [7:0]    ubank_q, cbank_q;
    logic          wr, ld, clr;
    logic [1:0]    ld_idx;
    logic [4:0]    ld_data;
    logic [PB-1:0] pbank;
    logic [CB-1:0] cbank;
    logic          unused_ok;

    assign wr        = ce & cpu_w & cpu_a[15];
    assign unused_ok = ppu_a[13];

    mmc1_loader u_loader (
        .clock  (clock),
        .reset  (reset),
        .ce_i   (ce),
        .wr_i   (wr),
        .en_i   (mode == MODE_MMC1),
        .d7_i   (cpu_d[7]),
        .d0_i   (cpu_d[0]),
        .idx_i  (cpu_a[14:13]),
        .ld_o   (ld),
        .clr_o  (clr),
        .idx_o  (ld_idx),
        .data_o (ld_data)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ctrl_q  <= CTRL_RESET;
            chr0_q  <= '0;
            chr1_q  <= '0;
            prg_q   <= '0;
            ubank_q <= '0;
            cbank_q <= '0;
        end else begin
            if (clr) begin
                ctrl_q <= ctrl_q | CTRL_RESET;
            end
            if (ld) begin
                unique case (ld_idx)
                    REG_CTRL: ctrl_q <= ld_data;
                    REG_CHR0: chr0_q <= ld_data;
                    REG_CHR1: chr1_q <= ld_data;
                    default:  prg_q  <= ld_data;
                endcase
            end
            if (wr && mode == MODE_UXROM) begin
                ubank_q <= cpu_d;
            end
            if (wr && mode == MODE_CNROM) begin
                cbank_q <= cpu_d;
            end
        end
    end

    // 16 KB PRG bank; bit 14 of cpu_a selects the $C000 half
    always_comb begin
        pbank = '0;
        unique case (ctrl_q[3:2])
            2'd2:    pbank = cpu_a[14] ? PB'(prg_q[3:0]) : '0;
            2'd3:    pbank = cpu_a[14] ? {PB{1'b1}} : PB'(prg_q[3:0]);
            default: pbank = PB'({prg_q[3:1], cpu_a[14]});
        endcase
    end

    always_comb begin
        cbank = '0;
        if (ctrl_q[4]) begin
            cbank = ppu_a[12] ? CB'(chr1_q) : CB'(chr0_q);
        end else begin
            cbank = CB'({chr0_q[4:1], ppu_a[12]});
        end
    end

    always_comb begin
        prg_a      = PRG_AW'(cpu_a[14:0]);
        chr_a      = CHR_AW'(ppu_a[12:0]);
        nt_a10     = mirror_v ? ppu_a[10] : ppu_a[11];
        prg_ram_en = 1'b1;
        chr_we     = chr_ram;
        unique case (mode)
            MODE_MMC1: begin
                prg_a      = {pbank, cpu_a[13:0]};
                chr_a      = {cbank, ppu_a[11:0]};
                prg_ram_en = ~prg_q[4];
                unique case (ctrl_q[1:0])
                    MIR_ONE_LO: nt_a10 = 1'b0;
                    MIR_ONE_HI: nt_a10 = 1'b1;
                    MIR_VERT:   nt_a10 = ppu_a[10];
                    default:    nt_a10 = ppu_a[11];
                endcase
            end
            MODE_UXROM: begin
                prg_a = cpu_a[14] ? {{PB{1'b1}}, cpu_a[13:0]}
                                  : {PB'(ubank_q), cpu_a[13:0]};
            end
            MODE_CNROM: begin
                chr_a = {CB'({cbank_q, ppu_a[12]}), ppu_a[11:0]};
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_nes_mapper.sv
// Directed bench for nes_mapper: MMC1 serial loads, UxROM, CNROM
// and NROM windows, with hand-computed expected addresses.
module tb_nes_mapper;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ce = 1'b1;
    logic [1:0]  mode = 2'd1;
    logic        mirror_v = 1'b0;
    logic        chr_ram = 1'b0;
    logic [15:0] cpu_a = 16'h0000;
    logic [7:0]  cpu_d = 8'h00;
    logic        cpu_w = 1'b0;
    logic [13:0] ppu_a = 14'h0000;
    logic [17:0] prg_a;
    logic [16:0] chr_a;
    logic        chr_we;
    logic        nt_a10;
    logic        prg_ram_en;

    int n_cmp = 0;
    int n_bad = 0;

    nes_mapper dut (
        .clock      (clock),
        .reset      (reset),
        .ce         (ce),
        .mode       (mode),
        .mirror_v   (mirror_v),
        .chr_ram    (chr_ram),
        .cpu_a      (cpu_a),
        .cpu_d      (cpu_d),
        .cpu_w      (cpu_w),
        .ppu_a      (ppu_a),
        .prg_a      (prg_a),
        .chr_a      (chr_a),
        .chr_we     (chr_we),
        .nt_a10     (nt_a10),
        .prg_ram_en (prg_ram_en)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        @(negedge clock);
        cpu_a = a;
        cpu_d = d;
        cpu_w = 1'b1;
        @(negedge clock);
        cpu_w = 1'b0;
    endtask

    task automatic ser(input logic [15:0] a, input logic [4:0] v);
        for (int i = 0; i < 5; i++) begin
            wr(a, {7'b0, v[i]});
        end
    endtask

    task automatic do_reset(input logic [1:0] m);
        @(negedge clock);
        reset = 1'b1;
        mode  = m;
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a, input logic [13:0] p);
        cpu_a = a;
        ppu_a = p;
        #1;
    endtask

    initial begin
        chr_ram = 1'b0;
        do_reset(2'd1);

        rd(16'hFFFC, 14'h1234);
        chk("rst_prg", 32'(prg_a), 32'h3FFFC);
        chk("rst_chr", 32'(chr_a), 32'h01234);
        chk("rst_ram", 32'(prg_ram_en), 32'd1);
        chk("rst_we", 32'(chr_we), 32'd0);
        chk("rst_ctrl", 32'(dut.ctrl_q), 32'h0C);
        rd(16'hFFFC, 14'h2400);
        chk("rst_nt", 32'(nt_a10), 32'd0);

        ser(16'hE000, 5'h05);
        rd(16'h8123, 14'h0000);
        chk("m1_prg5", 32'(prg_a), 32'h14123);
        rd(16'hC000, 14'h0000);
        chk("m1_last", 32'(prg_a), 32'h3C000);

        ser(16'h8000, 5'h12);
        rd(16'h8123, 14'h2400);
        chk("m1_32k_lo", 32'(prg_a), 32'h10123);
        chk("m1_ntv1", 32'(nt_a10), 32'd1);
        rd(16'hC001, 14'h2800);
        chk("m1_32k_hi", 32'(prg_a), 32'h14001);
        chk("m1_ntv0", 32'(nt_a10), 32'd0);

        ser(16'hA000, 5'h03);
        ser(16'hC000, 5'h1E);
        rd(16'h8000, 14'h0ABC);
        chk("m1_chr0", 32'(chr_a), 32'h03ABC);
        rd(16'h8000, 14'h1ABC);
        chk("m1_chr1", 32'(chr_a), 32'h1EABC);

        wr(16'hE000, 8'h01);
        wr(16'hE000, 8'h01);
        wr(16'hE000, 8'h80);
        chk("clr_cnt", 32'(dut.u_loader.count_q), 32'd0);
        chk("clr_ctrl", 32'(dut.ctrl_q), 32'h1E);
        rd(16'hC000, 14'h0000);
        chk("clr_last", 32'(prg_a), 32'h3C000);
        rd(16'h8123, 14'h0000);
        chk("clr_lo", 32'(prg_a), 32'h14123);
        ser(16'hE000, 5'h13);
        rd(16'h8010, 14'h0000);
        chk("fresh_prg", 32'(prg_a), 32'h0C010);
        chk("fresh_ram", 32'(prg_ram_en), 32'd0);

        @(negedge clock);
        cpu_a = 16'hE000;
        cpu_d = 8'h01;
        cpu_w = 1'b1;
        @(negedge clock);
        @(negedge clock);
        cpu_w = 1'b0;
        chk("rmw_cnt", 32'(dut.u_loader.count_q), 32'd1);
        for (int i = 0; i < 4; i++) begin
            wr(16'hE000, 8'h00);
        end
        rd(16'h8000, 14'h0000);
        chk("rmw_prg", 32'(prg_a), 32'h04000);
        chk("rmw_ram", 32'(prg_ram_en), 32'd1);

        rd(16'h8000, 14'h2400);
        chk("pre_nt", 32'(nt_a10), 32'd1);
        wr(16'hE000, 8'h01);
        wr(16'hE000, 8'h01);
        wr(16'hE000, 8'h01);
        #2;
        reset = 1'b1;
        #1;
        chk("async_ctrl", 32'(dut.ctrl_q), 32'h0C);
        chk("async_cnt", 32'(dut.u_loader.count_q), 32'd0);
        chk("async_nt", 32'(nt_a10), 32'd0);
        rd(16'h8000, 14'h1ABC);
        chk("async_prg", 32'(prg_a), 32'h00000);
        chk("async_chr", 32'(chr_a), 32'h01ABC);
        @(negedge clock);
        reset = 1'b0;
        ser(16'hE000, 5'h06);
        rd(16'h8000, 14'h0000);
        chk("post_prg", 32'(prg_a), 32'h18000);

        do_reset(2'd2);
        mirror_v = 1'b0;
        wr(16'h8000, 8'h03);
        rd(16'h9000, 14'h2800);
        chk("ux_lo", 32'(prg_a), 32'h0D000);
        chk("ux_nth", 32'(nt_a10), 32'd1);
        rd(16'hC000, 14'h1ABC);
        chk("ux_hi", 32'(prg_a), 32'h3C000);
        chk("ux_chr", 32'(chr_a), 32'h01ABC);
        chk("ux_ram", 32'(prg_ram_en), 32'd1);
        wr(16'hFFFF, 8'hFF);
        rd(16'h8000, 14'h0000);
        chk("ux_trunc", 32'(prg_a), 32'h3C000);

        do_reset(2'd3);
        mirror_v = 1'b1;
        wr(16'h8000, 8'h02);
        rd(16'hC123, 14'h0400);
        chk("cn_chr", 32'(chr_a), 32'h04400);
        chk("cn_prg", 32'(prg_a), 32'h04123);
        rd(16'hC123, 14'h2400);
        chk("cn_nt", 32'(nt_a10), 32'd1);

        do_reset(2'd0);
        chr_ram = 1'b1;
        rd(16'hF123, 14'h1ABC);
        chk("nr_prg", 32'(prg_a), 32'h07123);
        chk("nr_chr", 32'(chr_a), 32'h01ABC);
        chk("nr_we", 32'(chr_we), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
